// File: rtl/imm_gen_stage_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | imm_gen_stage_pkg : opcodes, format codes and buffer-entry sizing         |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
package imm_gen_stage_pkg;

  localparam logic [6:0] OPCODE_LOAD     = 7'h03;
  localparam logic [6:0] OPCODE_MISC_MEM = 7'h0F;
  localparam logic [6:0] OPCODE_OP_IMM   = 7'h13;
  localparam logic [6:0] OPCODE_AUIPC    = 7'h17;
  localparam logic [6:0] OPCODE_STORE    = 7'h23;
  localparam logic [6:0] OPCODE_OP       = 7'h33;
  localparam logic [6:0] OPCODE_LUI      = 7'h37;
  localparam logic [6:0] OPCODE_BRANCH   = 7'h63;
  localparam logic [6:0] OPCODE_JALR     = 7'h67;
  localparam logic [6:0] OPCODE_JAL      = 7'h6F;
  localparam logic [6:0] OPCODE_SYSTEM   = 7'h73;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6
  } fmt_e;

  // Entry layout is {imm, fmt, target, illegal}.
  function automatic int entry_width(input int xlen);
    return 2 * xlen + 3 + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/imm_gen_stage_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | imm_gen_stage_if : fetch-side and decode-side handshake bundle            |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
interface imm_gen_stage_if #(
  parameter int XLEN = 32
);
  logic            Flush_i;
  logic            In_valid_i;
  logic            In_ready_o;
  logic [31:0]     Inst_i;
  logic [XLEN-1:0] Pc_i;
  logic            Out_valid_o;
  logic            Out_ready_i;
  logic [XLEN-1:0] Imm_o;
  logic [2:0]      Fmt_o;
  logic [XLEN-1:0] Target_o;
  logic            Illegal_o;

  modport master (
    output Flush_i, In_valid_i, Inst_i, Pc_i, Out_ready_i,
    input  In_ready_o, Out_valid_o, Imm_o, Fmt_o, Target_o, Illegal_o
  );

  modport slave (
    input  Flush_i, In_valid_i, Inst_i, Pc_i, Out_ready_i,
    output In_ready_o, Out_valid_o, Imm_o, Fmt_o, Target_o, Illegal_o
  );
endinterface
`default_nettype wire

// File: rtl/imm_gen_stage_imm_decode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | imm_decode : combinational instruction -> {imm, fmt, target, illegal}     |
// | Optional macro IMM_GEN_CSR_EN enables the Z (CSR uimm) format.            |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module imm_decode
  import imm_gen_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_inst,
  input  logic [XLEN-1:0] i_pc,
  output logic [XLEN-1:0] o_imm,
  output logic [2:0]      o_fmt,
  output logic [XLEN-1:0] o_target,
  output logic            o_illegal
);

  logic [31:0] w_imm32;
  fmt_e        w_fmt;
  logic        w_has_target;
  logic        w_illegal;

  always_comb begin
    w_imm32      = '0;
    w_fmt        = FMT_NONE;
    w_has_target = 1'b0;
    w_illegal    = 1'b0;
    if (i_inst[1:0] != 2'b11) begin
      w_illegal = 1'b1;
    end else begin
      case (i_inst[6:0])
        OPCODE_OP_IMM, OPCODE_LOAD, OPCODE_JALR: begin
          w_fmt   = FMT_I;
          w_imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
        end
        OPCODE_STORE: begin
          w_fmt   = FMT_S;
          w_imm32 = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
        end
        OPCODE_BRANCH: begin
          w_fmt        = FMT_B;
          w_has_target = 1'b1;
          w_imm32      = {{19{i_inst[31]}}, i_inst[31], i_inst[7],
                          i_inst[30:25], i_inst[11:8], 1'b0};
        end
        OPCODE_LUI: begin
          w_fmt   = FMT_U;
          w_imm32 = {i_inst[31:12], 12'b0};
        end
        OPCODE_AUIPC: begin
          w_fmt        = FMT_U;
          w_has_target = 1'b1;
          w_imm32      = {i_inst[31:12], 12'b0};
        end
        OPCODE_JAL: begin
          w_fmt        = FMT_J;
          w_has_target = 1'b1;
          w_imm32      = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12],
                          i_inst[20], i_inst[30:21], 1'b0};
        end
        OPCODE_OP, OPCODE_MISC_MEM: begin
        end
        OPCODE_SYSTEM: begin
`ifdef IMM_GEN_CSR_EN
          // funct3[2] selects the immediate CSR forms; uimm is zero-extended.
          if (i_inst[14]) begin
            w_fmt   = FMT_Z;
            w_imm32 = {27'b0, i_inst[19:15]};
          end
`endif
        end
        default: w_illegal = 1'b1;
      endcase
    end
  end

  // Every 32-bit pattern above is already sign-correct, so widening is a plain sign-extend.
  assign o_imm     = XLEN'($signed(w_imm32));
  assign o_fmt     = w_fmt;
  assign o_illegal = w_illegal;
  assign o_target  = w_has_target ? (i_pc + o_imm) : '0;

endmodule
`default_nettype wire

// File: rtl/imm_gen_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | imm_gen_stage : registered immediate generator with DEPTH-entry buffer    |
// | Optional macro IMM_GEN_CSR_EN (see imm_decode) adds the Z format.         |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module imm_gen_stage
  import imm_gen_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  imm_gen_stage_if.slave bus
);

  localparam int         c_ENTRY_W = entry_width(XLEN);
  localparam logic [1:0] c_DEPTH   = 2'(DEPTH);

  logic [XLEN-1:0]      w_imm;
  logic [XLEN-1:0]      w_target;
  logic [2:0]           w_fmt;
  logic                 w_illegal;
  logic [c_ENTRY_W-1:0] w_entry;
  logic                 w_push;
  logic                 w_pop;

  logic [c_ENTRY_W-1:0] r_head;
  logic [c_ENTRY_W-1:0] r_tail;
  logic [1:0]           r_count;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .i_inst    (bus.Inst_i),
    .i_pc      (bus.Pc_i),
    .o_imm     (w_imm),
    .o_fmt     (w_fmt),
    .o_target  (w_target),
    .o_illegal (w_illegal)
  );

  assign w_entry = {w_imm, w_fmt, w_target, w_illegal};

  // Ready depends only on the registered count, so a full buffer refuses even on a pop cycle.
  assign bus.In_ready_o  = (r_count < c_DEPTH);
  assign bus.Out_valid_o = (r_count != 2'd0);
  assign w_push = bus.In_valid_i && bus.In_ready_o;
  assign w_pop  = bus.Out_valid_o && bus.Out_ready_i;

  assign {bus.Imm_o, bus.Fmt_o, bus.Target_o, bus.Illegal_o} = r_head;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_count <= 2'd0;
      r_head  <= '0;
      r_tail  <= '0;
    end else if (bus.Flush_i) begin
      r_count <= 2'd0;
    end else begin
      // Head is the oldest entry; tail only holds the second entry when DEPTH==2.
      if (w_push && ((r_count == 2'd0) || ((r_count == 2'd1) && w_pop))) begin
        r_head <= w_entry;
      end else if (w_pop) begin
        r_head <= r_tail;
      end
      if (w_push && (r_count == 2'd1) && !w_pop) begin
        r_tail <= w_entry;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 2'd1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 2'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_stage.sv
`default_nettype none
// tb_imm_gen_stage : scoreboard bench for imm_gen_stage, XLEN=32 and XLEN=64 instances, DEPTH=2.
module tb_imm_gen_stage;

  typedef struct packed {
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic [31:0] tgt;
    logic        ill;
  } exp32_t;

  typedef struct packed {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic [63:0] tgt;
    logic        ill;
  } exp64_t;

  localparam int NV   = 13;
  localparam int NV64 = 4;

  logic clk = 1'b0;
  logic rst_i;
  int   n_pass  = 0;
  int   n_total = 0;

  exp32_t sb32[$];
  exp64_t sb64[$];

  logic [31:0] v_inst [NV];
  logic [31:0] v_pc   [NV];
  exp32_t      v_exp  [NV];
  logic [31:0] w_inst [NV64];
  logic [63:0] w_pc   [NV64];
  exp64_t      w_exp  [NV64];

  always #5 clk = ~clk;

  imm_gen_stage_if #(.XLEN(32)) b32 ();
  imm_gen_stage_if #(.XLEN(64)) b64 ();

  imm_gen_stage #(.XLEN(32), .DEPTH(2)) dut32 (.clk_i(clk), .rst_i(rst_i), .bus(b32.slave));
  imm_gen_stage #(.XLEN(64), .DEPTH(2)) dut64 (.clk_i(clk), .rst_i(rst_i), .bus(b64.slave));

  task automatic load_vectors();
    v_inst[0]  = 32'hFFF00093; v_pc[0]  = 32'h0;        v_exp[0]  = '{32'hFFFFFFFF, 3'd1, 32'h0, 1'b0};
    v_inst[1]  = 32'hFE000EE3; v_pc[1]  = 32'h100;      v_exp[1]  = '{32'hFFFFFFFC, 3'd3, 32'h000000FC, 1'b0};
    v_inst[2]  = 32'h00512423; v_pc[2]  = 32'h0;        v_exp[2]  = '{32'h00000008, 3'd2, 32'h0, 1'b0};
    v_inst[3]  = 32'h12345097; v_pc[3]  = 32'h1000;     v_exp[3]  = '{32'h12345000, 3'd4, 32'h12346000, 1'b0};
    v_inst[4]  = 32'h010000EF; v_pc[4]  = 32'h200;      v_exp[4]  = '{32'h00000010, 3'd5, 32'h00000210, 1'b0};
    v_inst[5]  = 32'hFFDFF06F; v_pc[5]  = 32'h0;        v_exp[5]  = '{32'hFFFFFFFC, 3'd5, 32'hFFFFFFFC, 1'b0};
    v_inst[6]  = 32'h002081B3; v_pc[6]  = 32'h40;       v_exp[6]  = '{32'h0, 3'd0, 32'h0, 1'b0};
    v_inst[7]  = 32'hFFFFFFFF; v_pc[7]  = 32'h0;        v_exp[7]  = '{32'h0, 3'd0, 32'h0, 1'b1};
    v_inst[8]  = 32'hFFF00090; v_pc[8]  = 32'h0;        v_exp[8]  = '{32'h0, 3'd0, 32'h0, 1'b1};
    v_inst[9]  = 32'h300FD073; v_pc[9]  = 32'h0;
`ifdef IMM_GEN_CSR_EN
    v_exp[9] = '{32'h0000001F, 3'd6, 32'h0, 1'b0};
`else
    v_exp[9] = '{32'h0, 3'd0, 32'h0, 1'b0};
`endif
    v_inst[10] = 32'hFFC08067; v_pc[10] = 32'h500;      v_exp[10] = '{32'hFFFFFFFC, 3'd1, 32'h0, 1'b0};
    v_inst[11] = 32'h800000B7; v_pc[11] = 32'h0;        v_exp[11] = '{32'h80000000, 3'd4, 32'h0, 1'b0};
    v_inst[12] = 32'h00001017; v_pc[12] = 32'hFFFFF800; v_exp[12] = '{32'h00001000, 3'd4, 32'h00000800, 1'b0};
    w_inst[0] = 32'h800000B7; w_pc[0] = 64'h0;
    w_exp[0]  = '{64'hFFFFFFFF80000000, 3'd4, 64'h0, 1'b0};
    w_inst[1] = 32'h0000007F; w_pc[1] = 64'h0;
    w_exp[1]  = '{64'h0, 3'd0, 64'h0, 1'b1};
    w_inst[2] = 32'h00001017; w_pc[2] = 64'hFFFFFFFFFFFFF000;
    w_exp[2]  = '{64'h0000000000001000, 3'd4, 64'h0, 1'b0};
    w_inst[3] = 32'hFE000EE3; w_pc[3] = 64'h100;
    w_exp[3]  = '{64'hFFFFFFFFFFFFFFFC, 3'd3, 64'h00000000000000FC, 1'b0};
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    b32.Flush_i = 1'b0; b32.In_valid_i = 1'b0; b32.Inst_i = '0; b32.Pc_i = '0; b32.Out_ready_i = 1'b0;
    b64.Flush_i = 1'b0; b64.In_valid_i = 1'b0; b64.Inst_i = '0; b64.Pc_i = '0; b64.Out_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_total++;
    if ({b32.In_ready_o, b32.Out_valid_o} !== 2'b10)
      $display("FAIL reset_hs32: got %b expected 10", {b32.In_ready_o, b32.Out_valid_o});
    else n_pass++;
    n_total++;
    if ({b32.Imm_o, b32.Fmt_o, b32.Target_o, b32.Illegal_o} !== '0)
      $display("FAIL reset_data32: got %h expected 0", {b32.Imm_o, b32.Fmt_o, b32.Target_o, b32.Illegal_o});
    else n_pass++;
    n_total++;
    if ({b64.In_ready_o, b64.Out_valid_o} !== 2'b10)
      $display("FAIL reset_hs64: got %b expected 10", {b64.In_ready_o, b64.Out_valid_o});
    else n_pass++;
    n_total++;
    if ({b64.Imm_o, b64.Fmt_o, b64.Target_o, b64.Illegal_o} !== '0)
      $display("FAIL reset_data64: got %h expected 0", {b64.Imm_o, b64.Fmt_o, b64.Target_o, b64.Illegal_o});
    else n_pass++;
    rst_i = 1'b1;
  endtask

  // Back-to-back pushes with the consumer always ready: one entry per cycle, one cycle latency.
  task automatic test_decode();
    int sent = 0;
    int cyc  = 0;
    exp32_t got;
    exp32_t exp;
    b32.Out_ready_i = 1'b1;
    while ((sent < NV || sb32.size() > 0) && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (b32.Out_valid_o && b32.Out_ready_i) begin
        got = {b32.Imm_o, b32.Fmt_o, b32.Target_o, b32.Illegal_o};
        n_total++;
        if (sb32.size() == 0) $display("FAIL decode_unexpected: got %h expected no entry", got);
        else begin
          exp = sb32.pop_front();
          if (got !== exp) $display("FAIL decode_entry: got %h expected %h", got, exp);
          else n_pass++;
        end
      end
      if (sent < NV) begin
        b32.In_valid_i = 1'b1; b32.Inst_i = v_inst[sent]; b32.Pc_i = v_pc[sent];
        if (b32.In_ready_o) begin sb32.push_back(v_exp[sent]); sent++; end
      end else b32.In_valid_i = 1'b0;
    end
    n_total++;
    if (cyc !== NV + 1) $display("FAIL decode_throughput: got %0d cycles expected %0d", cyc, NV + 1);
    else n_pass++;
  endtask

  // Three pushes into a stalled buffer, then release the consumer.
  task automatic test_backpressure();
    int sent = 0;
    int cyc  = 0;
    exp32_t got;
    exp32_t exp;
    while ((sent < 3 || sb32.size() > 0) && cyc < 50) begin
      @(negedge clk);
      b32.Out_ready_i = (cyc >= 3);
      if (cyc == 2 || cyc == 4) begin
        n_total++;
        if (b32.In_ready_o !== (cyc == 4))
          $display("FAIL bp_in_ready_c%0d: got %b expected %b", cyc, b32.In_ready_o, (cyc == 4));
        else n_pass++;
      end
      if (cyc == 2) begin
        n_total++;
        if (sb32.size() == 0 || b32.Out_valid_o !== 1'b1 || b32.Imm_o !== sb32[0].imm)
          $display("FAIL bp_head_hold: got valid %b imm %h expected valid 1 imm %h", b32.Out_valid_o, b32.Imm_o, v_exp[0].imm);
        else n_pass++;
      end
      if (b32.Out_valid_o && b32.Out_ready_i) begin
        got = {b32.Imm_o, b32.Fmt_o, b32.Target_o, b32.Illegal_o};
        n_total++;
        if (sb32.size() == 0) $display("FAIL bp_unexpected: got %h expected no entry", got);
        else begin
          exp = sb32.pop_front();
          if (got !== exp) $display("FAIL bp_order: got %h expected %h", got, exp);
          else n_pass++;
        end
      end
      if (sent < 3) begin
        b32.In_valid_i = 1'b1; b32.Inst_i = v_inst[sent]; b32.Pc_i = v_pc[sent];
        if (b32.In_ready_o) begin sb32.push_back(v_exp[sent]); sent++; end
      end else b32.In_valid_i = 1'b0;
      cyc++;
    end
    n_total++;
    if (sent !== 3 || sb32.size() !== 0)
      $display("FAIL bp_timeout: got sent %0d pending %0d expected 3 and 0", sent, sb32.size());
    else n_pass++;
  endtask

  task automatic test_flush();
    exp32_t got;
    @(negedge clk);
    b32.Out_ready_i = 1'b0;
    b32.In_valid_i = 1'b1; b32.Inst_i = v_inst[0]; b32.Pc_i = v_pc[0];
    @(negedge clk);
    n_total++;
    if (b32.Out_valid_o !== 1'b1) $display("FAIL flush_pre_valid: got %b expected 1", b32.Out_valid_o);
    else n_pass++;
    b32.Flush_i = 1'b1; b32.Inst_i = v_inst[1]; b32.Pc_i = v_pc[1];
    @(negedge clk);
    b32.Flush_i = 1'b0; b32.In_valid_i = 1'b0;
    n_total++;
    if ({b32.Out_valid_o, b32.In_ready_o} !== 2'b01)
      $display("FAIL flush_empty: got valid/ready %b expected 01", {b32.Out_valid_o, b32.In_ready_o});
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (b32.Out_valid_o !== 1'b0) $display("FAIL flush_no_ghost: got %b expected 0", b32.Out_valid_o);
    else n_pass++;
    b32.Out_ready_i = 1'b1;
    b32.In_valid_i = 1'b1; b32.Inst_i = v_inst[3]; b32.Pc_i = v_pc[3];
    @(negedge clk);
    b32.In_valid_i = 1'b0;
    got = {b32.Imm_o, b32.Fmt_o, b32.Target_o, b32.Illegal_o};
    n_total++;
    if (b32.Out_valid_o !== 1'b1 || got !== v_exp[3])
      $display("FAIL flush_recover: got valid %b %h expected valid 1 %h", b32.Out_valid_o, got, v_exp[3]);
    else n_pass++;
    // Reset in the middle of a stream drops the held entry and clears the data.
    @(negedge clk);
    b32.Out_ready_i = 1'b0;
    b32.In_valid_i = 1'b1; b32.Inst_i = v_inst[4]; b32.Pc_i = v_pc[4];
    @(negedge clk);
    b32.In_valid_i = 1'b0;
    rst_i = 1'b0;
    @(negedge clk);
    n_total++;
    if (b32.Out_valid_o !== 1'b0 || b32.Imm_o !== 32'h0 || b32.Target_o !== 32'h0)
      $display("FAIL reset_mid: got valid %b imm %h tgt %h expected 0 0 0", b32.Out_valid_o, b32.Imm_o, b32.Target_o);
    else n_pass++;
    rst_i = 1'b1;
  endtask

  task automatic test_xlen64();
    int sent = 0;
    int cyc  = 0;
    exp64_t got;
    exp64_t exp;
    b64.Out_ready_i = 1'b1;
    while ((sent < NV64 || sb64.size() > 0) && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (b64.Out_valid_o && b64.Out_ready_i) begin
        got = {b64.Imm_o, b64.Fmt_o, b64.Target_o, b64.Illegal_o};
        n_total++;
        if (sb64.size() == 0) $display("FAIL x64_unexpected: got %h expected no entry", got);
        else begin
          exp = sb64.pop_front();
          if (got !== exp) $display("FAIL x64_entry: got %h expected %h", got, exp);
          else n_pass++;
        end
      end
      if (sent < NV64) begin
        b64.In_valid_i = 1'b1; b64.Inst_i = w_inst[sent]; b64.Pc_i = w_pc[sent];
        if (b64.In_ready_o) begin sb64.push_back(w_exp[sent]); sent++; end
      end else b64.In_valid_i = 1'b0;
    end
    n_total++;
    if (sent !== NV64 || sb64.size() !== 0)
      $display("FAIL x64_timeout: got sent %0d pending %0d expected %0d and 0", sent, sb64.size(), NV64);
    else n_pass++;
  endtask

  initial begin
    load_vectors();
    test_reset();
    test_decode();
    test_backpressure();
    test_flush();
    test_xlen64();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
